button_parser: RTL and testbench
================================

// Module: button_parser
//
// PURPOSE
//  Conditions the raw push-button inputs before they reach the square-wave generator's
//  buttons[] port. Each bit goes through a 2-flop synchronizer, a sampled saturating
//  debouncer and a rising-edge detector. A clean press therefore produces exactly one
//  clk-wide pulse. A qualified debounced level is also exported for status LEDs.
//
// PARAMETERS
//  WIDTH          3       number of independent button channels
//  SAMPLE_CNT_MAX 62500   clk cycles per debounce sample tick (125 MHz -> 2 kHz)
//  PULSE_CNT_MAX  200     consecutive high samples needed to qualify a press (~100 ms)
//
// PORTS
//  clk    in   1      system clock
//  rst    in   1      synchronous, active-high reset
//  in     in   WIDTH  raw asynchronous button levels, active-high
//  out    out  WIDTH  one-cycle press pulses, one per qualified press
//  level  out  WIDTH  debounced level: high while press is qualified and held
//
// BEHAVIOUR
//  - Reset: sync flops, sample counter, all saturating counters and edge-detect regs go to 0.
//    Therefore out = 0 and level = 0 in the cycle after rst is sampled high.
//  - Sync: in -> s1 -> s2, with 2 clk of latency. Only s2 is used downstream. No reset-free flops.
//  - Sample tick: a free-running counter counts 0..SAMPLE_CNT_MAX-1 and wraps to 0.
//    - tick = 1 in the cycle the count equals SAMPLE_CNT_MAX-1.
//    - The counter is shared by all channels.
//    - Counter width = $clog2(SAMPLE_CNT_MAX).
//  - Per channel i, saturating counter cnt[i], width $clog2(PULSE_CNT_MAX+1):
//    - s2[i] == 0: cnt[i] <= 0 on every cycle, regardless of tick. Any glitch low restarts qualification.
//    - s2[i] == 1 && tick: cnt[i] <= min(cnt[i]+1, PULSE_CNT_MAX).
//    - Otherwise cnt[i] holds.
//  - level[i] = (cnt[i] == PULSE_CNT_MAX). This is combinational from a register, so it is glitch-free.
//  - Edge detect: lvl_d[i] <= level[i]; out[i] = level[i] & ~lvl_d[i]. Exactly one cycle high per qualification.
//  - Holding a button emits a single pulse. The button must be released (cnt cleared) before another pulse can occur.
//  - Channels are fully independent. Simultaneous presses give simultaneous pulses if they qualify on the same tick.
//  - Press latency: 2 sync cycles + up to PULSE_CNT_MAX ticks + 1 cycle.
//  - Reset mid-press: all qualification progress is lost. A button still held after rst deasserts must
//    re-qualify fully, then emits one pulse.
//  - rst asserted in the same cycle as a tick or an input change: reset wins.
//
// STRUCTURE
//  - Shared package: no typedefs required. Keep the default sample/pulse constants in
//    lab-wide defines so all button users agree on timing.
//  - Sub-module debouncer (WIDTH, SAMPLE_CNT_MAX, PULSE_CNT_MAX), containing the sample
//    counter and the per-channel saturating counters, with output level.
//  - Synchronizer and edge detector stay inline in button_parser.
//
// TESTING (bench params: WIDTH=3, SAMPLE_CNT_MAX=4, PULSE_CNT_MAX=3)
//  1. Reset: hold in=3'b111 through rst, release rst -> out=0, level=0 for >=10 cycles.
//     Then exactly one pulse per bit.
//  2. Clean press: in[0] 0->1, held 40 cycles -> out[0] is one cycle high, 10..16 cycles after the edge.
//     level[0] stays high until release. out[2:1] stay 0.
//  3. Bounce: in[1] toggles every 2 cycles for 20 cycles, then stays high -> no pulse during bouncing.
//     Exactly one pulse after the stable phase qualifies.
//  4. Hold/repress: in[2] high 60 cycles, low 10, high 60 -> exactly two pulses.
//     level[2] drops within 3 cycles of the release.
//  5. Simultaneous: in=3'b101 on the same cycle -> out[0] and out[2] pulse on the same cycle.
//  6. Reset mid-qualify: assert rst 1 cycle while in[0] has been high 8 cycles -> no pulse before full
//     re-qualification, then one pulse.

Source files
------------

// File: rtl/button_parser_pkg.sv
// Shared button-timing constants so every button consumer agrees on debounce timing.
// Defaults target a 125 MHz clock: 2 kHz sample tick, 200 samples (~100 ms) to qualify.
package button_parser_pkg;

  localparam int unsigned BTN_WIDTH_DEF          = 3;
  localparam int unsigned BTN_SAMPLE_CNT_MAX_DEF = 62500;
  localparam int unsigned BTN_PULSE_CNT_MAX_DEF  = 200;

  // Counter width able to hold 0..max_val-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction

endpackage : button_parser_pkg

// File: rtl/button_parser_debouncer.sv
// Sampled saturating debouncer for synchronized button levels.
//   clk, rst : clock, synchronous active-high reset
//   sync_i   : [WIDTH] synchronized button levels
//   level_o  : [WIDTH] high while a channel has seen PULSE_CNT_MAX consecutive high samples
module button_parser_debouncer
  import button_parser_pkg::*;
#(
  parameter int unsigned WIDTH          = BTN_WIDTH_DEF,
  parameter int unsigned SAMPLE_CNT_MAX = BTN_SAMPLE_CNT_MAX_DEF,
  parameter int unsigned PULSE_CNT_MAX  = BTN_PULSE_CNT_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sync_i,
  output logic [WIDTH-1:0] level_o
);

  localparam int unsigned SW = cnt_width(SAMPLE_CNT_MAX);
  localparam int unsigned PW = cnt_width(PULSE_CNT_MAX + 1);

  localparam logic [SW-1:0] SAMPLE_LAST = SW'(SAMPLE_CNT_MAX - 1);
  localparam logic [PW-1:0] PULSE_SAT   = PW'(PULSE_CNT_MAX);

  logic [SW-1:0]           sample_q, sample_d;
  logic                    tick;
  logic [WIDTH-1:0][PW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]        level_q, level_d;

  // Free-running sample counter shared by all channels.
  always_comb begin
    tick     = (sample_q == SAMPLE_LAST);
    sample_d = tick ? '0 : sample_q + SW'(1);
  end

  // Per-channel saturating counters; any low sample restarts qualification.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (!sync_i[i]) begin
        cnt_d[i] = '0;
      end else if (tick && (cnt_q[i] != PULSE_SAT)) begin
        cnt_d[i] = cnt_q[i] + PW'(1);
      end
      level_d[i] = (cnt_d[i] == PULSE_SAT);
    end
  end

  // level_q tracks (cnt_q == PULSE_SAT) cycle for cycle, straight from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_q <= '0;
      cnt_q    <= '0;
      level_q  <= '0;
    end else begin
      sample_q <= sample_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
    end
  end

  assign level_o = level_q;

endmodule : button_parser_debouncer

// File: rtl/button_parser.sv
// Push-button conditioner: 2-flop synchronizer, sampled debouncer, rising-edge detector.
//   clk, rst : clock, synchronous active-high reset
//   in       : [WIDTH] raw asynchronous button levels, active-high
//   out      : [WIDTH] one-cycle pulse per qualified press
//   level    : [WIDTH] debounced level, high while a qualified press is held
module button_parser
  import button_parser_pkg::*;
#(
  parameter int unsigned WIDTH          = BTN_WIDTH_DEF,
  parameter int unsigned SAMPLE_CNT_MAX = BTN_SAMPLE_CNT_MAX_DEF,
  parameter int unsigned PULSE_CNT_MAX  = BTN_PULSE_CNT_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] level
);

  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] lvl_q;

  // Synchronizer and edge-detect history; all reset so a held button must re-qualify.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q  <= '0;
      s2_q  <= '0;
      lvl_q <= '0;
    end else begin
      s1_q  <= in;
      s2_q  <= s1_q;
      lvl_q <= level;
    end
  end

  button_parser_debouncer #(
    .WIDTH          (WIDTH),
    .SAMPLE_CNT_MAX (SAMPLE_CNT_MAX),
    .PULSE_CNT_MAX  (PULSE_CNT_MAX)
  ) u_debouncer (
    .clk     (clk),
    .rst     (rst),
    .sync_i  (s2_q),
    .level_o (level)
  );

  // Rising edge of the debounced level; both operands come straight from flops.
  assign out = level & ~lvl_q;

endmodule : button_parser

// File: tb/tb_button_parser.sv
// Directed + randomized bench for button_parser against a run-length/tick-count model.
module tb_button_parser;

  localparam int W = 3;
  localparam int S = 4;
  localparam int P = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_v;
  logic [W-1:0] out_v;
  logic [W-1:0] level_v;

  always #5 clk = ~clk;

  button_parser #(
    .WIDTH          (W),
    .SAMPLE_CNT_MAX (S),
    .PULSE_CNT_MAX  (P)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .in    (in_v),
    .out   (out_v),
    .level (level_v)
  );

  int checks   = 0;
  int failures = 0;

  // Model: edges since reset, history of sampled inputs, start edge of each high run.
  int           edge_idx;
  logic [W-1:0] hist[$];
  int           run_start[W];
  logic [W-1:0] lvl_prev, exp_out, exp_lvl;

  int gcyc = 0;
  int pulse_cnt[W];
  int last_pulse[W];

  // Level is high once the current uninterrupted high run of the synchronized input
  // has contained P sample ticks; ticks fall on edges where edge_idx % S == S-1.
  task automatic model_edge(input logic r, input logic [W-1:0] v);
    logic [W-1:0] s2;
    int           ticks;
    if (r) begin
      edge_idx = 0;
      hist.delete();
      for (int i = 0; i < W; i++) run_start[i] = -1;
      lvl_prev = '0;
      exp_out  = '0;
      exp_lvl  = '0;
    end else begin
      hist.push_back(v);
      s2 = (edge_idx >= 2) ? hist[edge_idx-2] : '0;
      for (int i = 0; i < W; i++) begin
        if (!s2[i]) begin
          run_start[i] = -1;
          exp_lvl[i]   = 1'b0;
        end else begin
          if (run_start[i] < 0) run_start[i] = edge_idx;
          ticks      = (edge_idx + 1) / S - run_start[i] / S;
          exp_lvl[i] = (ticks >= P);
        end
      end
      exp_out  = exp_lvl & ~lvl_prev;
      lvl_prev = exp_lvl;
      edge_idx++;
    end
  endtask

  task automatic check_vec(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, gcyc, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, gcyc, obs, exp);
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < W; i++) begin
      pulse_cnt[i]  = 0;
      last_pulse[i] = -1;
    end
  endtask

  // One clock: drive, let the edge happen, advance the model, compare, tally pulses.
  task automatic cyc(input logic [W-1:0] v, input logic r = 1'b0);
    in_v = v;
    rst  = r;
    @(posedge clk);
    #1;
    model_edge(r, v);
    gcyc++;
    check_vec("out", out_v, exp_out);
    check_vec("level", level_v, exp_lvl);
    for (int i = 0; i < W; i++) begin
      if (out_v[i]) begin
        pulse_cnt[i]++;
        last_pulse[i] = gcyc;
      end
    end
  endtask

  initial begin
    int t_press;
    int drop;
    int lat_ok;
    logic [W-1:0] rv;
    int hold[W];

    in_v = '0;
    rst  = 1'b1;
    clear_counts();

    // 1. Buttons held through reset: quiet for 10 cycles, then one pulse each.
    repeat (3) cyc(3'b111, 1'b1);
    check_vec("t1_reset_out", out_v, 3'b000);
    check_vec("t1_reset_level", level_v, 3'b000);
    clear_counts();
    repeat (10) begin
      cyc(3'b111);
      check_vec("t1_quiet_out", out_v, 3'b000);
      check_vec("t1_quiet_level", level_v, 3'b000);
    end
    repeat (20) cyc(3'b111);
    for (int i = 0; i < W; i++) check_int("t1_pulses", pulse_cnt[i], 1);
    repeat (6) cyc(3'b000);

    // 2. Clean press on bit 0.
    clear_counts();
    t_press = gcyc + 1;
    repeat (40) cyc(3'b001);
    check_int("t2_pulses0", pulse_cnt[0], 1);
    check_int("t2_pulses21", pulse_cnt[1] + pulse_cnt[2], 0);
    lat_ok = ((last_pulse[0] - t_press) >= 10 && (last_pulse[0] - t_press) <= 16) ? 1 : 0;
    check_int("t2_latency_in_range", lat_ok, 1);
    check_int("t2_level_held", int'(level_v[0]), 1);
    repeat (6) cyc(3'b000);

    // 3. Bounce on bit 1, then stable.
    clear_counts();
    for (int k = 0; k < 10; k++) repeat (2) cyc((k % 2 == 0) ? 3'b010 : 3'b000);
    check_int("t3_bounce_pulses", pulse_cnt[1], 0);
    repeat (30) cyc(3'b010);
    check_int("t3_stable_pulses", pulse_cnt[1], 1);
    repeat (6) cyc(3'b000);

    // 4. Hold / release / re-press on bit 2.
    clear_counts();
    repeat (60) cyc(3'b100);
    check_int("t4_hold_pulses", pulse_cnt[2], 1);
    drop = -1;
    for (int j = 1; j <= 10; j++) begin
      cyc(3'b000);
      if (!level_v[2] && drop < 0) drop = j;
    end
    check_int("t4_level_drop_fast", (drop >= 1 && drop <= 3) ? 1 : 0, 1);
    repeat (60) cyc(3'b100);
    check_int("t4_total_pulses", pulse_cnt[2], 2);
    repeat (6) cyc(3'b000);

    // 5. Simultaneous press on bits 0 and 2.
    clear_counts();
    repeat (30) cyc(3'b101);
    check_int("t5_pulses0", pulse_cnt[0], 1);
    check_int("t5_pulses1", pulse_cnt[1], 0);
    check_int("t5_pulses2", pulse_cnt[2], 1);
    check_int("t5_same_cycle", last_pulse[0], last_pulse[2]);
    repeat (6) cyc(3'b000);

    // 6. Reset while bit 0 is partway through qualification.
    clear_counts();
    repeat (8) cyc(3'b001);
    check_int("t6_pre_rst_pulses", pulse_cnt[0], 0);
    cyc(3'b001, 1'b1);
    repeat (10) cyc(3'b001);
    check_int("t6_early_pulses", pulse_cnt[0], 0);
    repeat (20) cyc(3'b001);
    check_int("t6_requal_pulses", pulse_cnt[0], 1);
    repeat (6) cyc(3'b000);

    // Random phase: per-bit random hold lengths, occasional reset.
    rv = '0;
    for (int i = 0; i < W; i++) hold[i] = 0;
    repeat (1500) begin
      for (int i = 0; i < W; i++) begin
        if (hold[i] == 0) begin
          rv[i]   = ~rv[i];
          hold[i] = int'($urandom_range(1, 25));
        end
        hold[i]--;
      end
      cyc(rv, ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_button_parser
